// File: rtl/conv_pkg.sv
// Shared geometry, run length and loader state encoding for the conv layer slice.
package conv_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int IMG_W      = 32;
  localparam int IMG_H      = 32;
  localparam int K          = 5;
  localparam int OUT_W      = IMG_W - K + 1;
  localparam int OUT_H      = IMG_H - K + 1;
  // One cycle per output pixel of the conv layer.
  localparam int RUN_CYCLES = OUT_W * OUT_H;

  typedef enum logic [1:0] {
    LOAD_FILTER = 2'd0,
    LOAD_IMAGE  = 2'd1,
    RUN         = 2'd2,
    DONE        = 2'd3
  } loader_state_t;

endpackage

// File: rtl/conv_input_loader.sv
// Deserialises a filter+image word stream into flat buses and sequences the conv layer run window.
// Latency: word lands in its bus slot on the accepting edge; result_valid follows RUN_CYCLES after conv_reset falls.
// Backpressure: in_ready is high only while loading; words offered during RUN/DONE wait upstream.
module conv_input_loader #(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int IMG_W      = conv_pkg::IMG_W,
  parameter int IMG_H      = conv_pkg::IMG_H,
  parameter int K          = conv_pkg::K,
  parameter int RUN_CYCLES = conv_pkg::RUN_CYCLES
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [K*K*DATA_WIDTH-1:0]         filter,
  output logic [IMG_W*IMG_H*DATA_WIDTH-1:0] image,
  output logic                              conv_reset,
  output logic                              result_valid,
  input  logic                              result_ack,
  output logic                              busy
);

  import conv_pkg::*;

  localparam int NF     = K * K;
  localparam int NI     = IMG_W * IMG_H;
  localparam int BEAT_W = $clog2(NI);
  localparam int RUN_W  = $clog2(RUN_CYCLES + 1);

  localparam logic [BEAT_W-1:0] LAST_F   = BEAT_W'(NF - 1);
  localparam logic [BEAT_W-1:0] LAST_I   = BEAT_W'(NI - 1);
  localparam logic [RUN_W-1:0]  LAST_RUN = RUN_W'(RUN_CYCLES - 1);

  loader_state_t     state;
  logic [BEAT_W-1:0] beat_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic              xfer;

  // Handshake outputs come from state only, so no input reaches them combinationally.
  assign in_ready     = (state == LOAD_FILTER) || (state == LOAD_IMAGE);
  assign conv_reset   = in_ready;
  assign busy         = !in_ready;
  assign result_valid = (state == DONE);
  assign xfer         = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= LOAD_FILTER;
      beat_cnt <= '0;
      run_cnt  <= '0;
      filter   <= '0;
      image    <= '0;
    end else begin
      case (state)
        LOAD_FILTER: begin
          if (xfer) begin
            // MSB-first: beat 0 lands in the top slot.
            filter[(NF - 1 - int'(beat_cnt)) * DATA_WIDTH +: DATA_WIDTH] <= in_data;
            if (beat_cnt == LAST_F) begin
              state    <= LOAD_IMAGE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        LOAD_IMAGE: begin
          if (xfer) begin
            image[(NI - 1 - int'(beat_cnt)) * DATA_WIDTH +: DATA_WIDTH] <= in_data;
            if (beat_cnt == LAST_I) begin
              state    <= RUN;
              beat_cnt <= '0;
              run_cnt  <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (run_cnt == LAST_RUN) begin
            state <= DONE;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        DONE: begin
          if (result_ack) begin
            state   <= LOAD_FILTER;
            run_cnt <= '0;
          end
        end
        default: state <= LOAD_FILTER;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_input_loader.sv
// Randomised stream bench for conv_input_loader with a word-count reference model and per-cycle compare.
module tb_conv_input_loader;

  localparam int DW  = 32;
  localparam int NF  = 25;
  localparam int NI  = 1024;
  localparam int NW  = NF + NI;
  localparam int RUN = 784;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n    = 1'b1;
  logic [DW-1:0]     in_data    = '0;
  logic              in_valid   = 1'b0;
  logic              result_ack = 1'b0;
  logic              in_ready;
  logic [NF*DW-1:0]  filter;
  logic [NI*DW-1:0]  image;
  logic              conv_reset;
  logic              result_valid;
  logic              busy;

  conv_input_loader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .filter       (filter),
    .image        (image),
    .conv_reset   (conv_reset),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: words accepted this frame, cycles spent running, and the written words.
  int          m_words = 0;
  int          m_run   = 0;
  bit          m_done  = 1'b0;
  logic [31:0] m_filt [NF];
  logic [31:0] m_img  [NI];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_words <= 0;
      m_run   <= 0;
      m_done  <= 1'b0;
      for (int i = 0; i < NF; i++) m_filt[i] <= '0;
      for (int i = 0; i < NI; i++) m_img[i]  <= '0;
    end else if (m_words < NW) begin
      if (in_valid) begin
        if (m_words < NF) m_filt[m_words] <= in_data;
        else              m_img[m_words - NF] <= in_data;
        m_words <= m_words + 1;
        m_run   <= 0;
      end
    end else if (!m_done) begin
      m_run  <= m_run + 1;
      m_done <= (m_run + 1 == RUN);
    end else if (result_ack) begin
      m_words <= 0;
      m_done  <= 1'b0;
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      int bad;
      check("in_ready",     {31'b0, in_ready},     {31'b0, m_words < NW});
      check("conv_reset",   {31'b0, conv_reset},   {31'b0, m_words < NW});
      check("busy",         {31'b0, busy},         {31'b0, m_words >= NW});
      check("result_valid", {31'b0, result_valid}, {31'b0, m_done});
      bad = -1;
      for (int i = 0; i < NF; i++)
        if (bad < 0 && filter[(NF-1-i)*DW +: DW] !== m_filt[i]) bad = i;
      n_checks++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL filter_bus word %0d: got %h, expected %h at %0t",
                 bad, filter[(NF-1-bad)*DW +: DW], m_filt[bad], $time);
      end
      bad = -1;
      for (int i = 0; i < NI; i++)
        if (bad < 0 && image[(NI-1-i)*DW +: DW] !== m_img[i]) bad = i;
      n_checks++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL image_bus word %0d: got %h, expected %h at %0t",
                 bad, image[(NI-1-bad)*DW +: DW], m_img[bad], $time);
      end
    end
  end

  function automatic logic [31:0] word_of(input int mode, input int idx);
    if (mode == 0)      return (idx < NF) ? 32'(idx) : 32'(idx - NF);
    else if (mode == 1) return 32'h40800000;
    else                return $urandom;
  endfunction

  // Offers one word with random holes; returns just after the accepting edge.
  task automatic send_word(input logic [31:0] d, input int gap_pct);
    bit acc = 1'b0;
    int guard = 0;
    while (!acc) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = in_valid ? d : $urandom;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (guard > 200) begin
        $display("FAIL send_word: in_ready stuck low, got 0, expected 1");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "stream stalled");
      end
    end
  endtask

  task automatic load_words(input int mode, input int gap_pct, input int count);
    for (int i = 0; i < count; i++) send_word(word_of(mode, i), gap_pct);
  endtask

  // ack_mode: 0 low, 1 held high, 2 high for the first 700 run cycles then low.
  task automatic wait_run(input bit hold_valid, input int ack_mode);
    int n = 0;
    in_valid = hold_valid;
    @(negedge clk);
    check("conv_reset_falls_after_last_beat", {31'b0, conv_reset}, 32'd0);
    while (!result_valid && n < 2000) begin
      @(posedge clk);
      #1;
      result_ack = (ack_mode == 1) || (ack_mode == 2 && n < 700);
      if (hold_valid) in_data = $urandom;
      @(negedge clk);
      n++;
    end
    check("run_window_length", n, RUN);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_in_ready",     {31'b0, in_ready},     32'd1);
    check("rst_conv_reset",   {31'b0, conv_reset},   32'd1);
    check("rst_result_valid", {31'b0, result_valid}, 32'd0);
    check("rst_busy",         {31'b0, busy},         32'd0);
    check("rst_filter_zero",  {31'b0, filter == '0}, 32'd1);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Ramp frame with holes and a spurious ack through loading and most of RUN.
    result_ack = 1'b1;
    load_words(0, 30, NW);
    wait_run(1'b0, 2);
    check("ramp_filter_top",  filter[799:768],   32'd0);
    check("ramp_filter_next", filter[767:736],   32'd1);
    check("ramp_filter_bot",  filter[31:0],      32'd24);
    check("ramp_image_top",   image[32767:32736], 32'd0);
    check("ramp_image_bot",   image[31:0],       32'd1023);

    repeat (50) begin
      @(negedge clk);
      check("done_hold_valid", {31'b0, result_valid}, 32'd1);
      check("done_hold_ready", {31'b0, in_ready},     32'd0);
    end
    @(posedge clk);
    #1 result_ack = 1'b1;
    @(posedge clk);
    #1 result_ack = 1'b0;
    @(negedge clk);
    check("ack_conv_reset",   {31'b0, conv_reset},   32'd1);
    check("ack_in_ready",     {31'b0, in_ready},     32'd1);
    check("ack_result_valid", {31'b0, result_valid}, 32'd0);
    repeat (5) @(negedge clk);
    check("ack_keeps_filter", filter[31:0], 32'd24);
    check("ack_keeps_image",  image[31:0],  32'd1023);

    // Constant 4.0 frame at full rate, valid held through RUN/DONE, ack held high.
    @(posedge clk);
    #1 result_ack = 1'b1;
    load_words(1, 0, NW);
    wait_run(1'b1, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    result_ack = 1'b0;
    @(negedge clk);
    check("const_image_bot",  image[31:0],     32'h40800000);
    check("const_filter_top", filter[799:768], 32'h40800000);

    // Random frame interrupted by reset after 300 image words.
    load_words(2, 40, NF + 300);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    check("midrst_filter_zero", {31'b0, filter == '0}, 32'd1);
    check("midrst_image_zero",  {31'b0, image == '0},  32'd1);
    check("midrst_in_ready",    {31'b0, in_ready},     32'd1);
    check("midrst_busy",        {31'b0, busy},         32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Fresh random frame, then a single-cycle ack.
    load_words(2, 20, NW);
    wait_run(1'b0, 0);
    @(posedge clk);
    #1 result_ack = 1'b1;
    @(posedge clk);
    #1 result_ack = 1'b0;
    @(negedge clk);
    check("final_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
